// File: rtl/deadline_tracker_pkg.sv
// Shared game definitions for the deadline chase: state encoding, screen and
// sprite geometry, coordinate widths and the 1-D box overlap helper.
package deadline_tracker_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_CAUGHT = 2'd3;

  localparam int DEF_SCREEN_W    = 1280;
  localparam int DEF_SCREEN_H    = 1024;
  localparam int DEF_SPRITE_SIZE = 256;

  localparam int X_W    = 11;
  localparam int Y_W    = 10;
  localparam int STEP_W = 4;
  localparam int CMP_W  = 12;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pos_t;

  // Strict inequalities: boxes that only share an edge do not overlap.
  function automatic logic span_overlap(input logic [CMP_W-1:0] p,
                                        input logic [CMP_W-1:0] psz,
                                        input logic [CMP_W-1:0] d,
                                        input logic [CMP_W-1:0] dsz);
    return (p < d + dsz) && (p + psz > d);
  endfunction

endpackage

// File: rtl/deadline_tracker_axis.sv
// One axis of deadline movement: step toward a signed target, snap when
// within one step, clamp to [0, max_pos]. Purely combinational.
module axis_stepper
  import deadline_tracker_pkg::*;
#(
  parameter int W = 11
) (
  input  logic [W-1:0]      pos,
  input  logic signed [W:0] target,
  input  logic [STEP_W-1:0] step,
  input  logic [W-1:0]      max_pos,
  output logic [W-1:0]      next_pos
);

  // Two extra bits so target-pos and pos-step never wrap.
  logic signed [W+1:0] p_s, t_s, s_s, m_s, diff, raw;

  assign p_s  = $signed({2'b00, pos});
  assign t_s  = $signed({target[W], target});
  assign s_s  = $signed((W+2)'(step));
  assign m_s  = $signed({2'b00, max_pos});
  assign diff = t_s - p_s;

  always_comb begin
    raw = t_s;
    if (diff > s_s)       raw = p_s + s_s;
    else if (diff < -s_s) raw = p_s - s_s;

    next_pos = raw[W-1:0];
    if (raw < 0)        next_pos = '0;
    else if (raw > m_s) next_pos = max_pos;
  end

endmodule

// File: rtl/deadline_tracker.sv
// Deadline sprite position and chase FSM: moves toward the player once per
// frame, ramps its speed, and flags a catch on box overlap.
module deadline_tracker
  import deadline_tracker_pkg::*;
#(
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int SPRITE_SIZE = DEF_SPRITE_SIZE,
  parameter int PLAYER_SIZE = 32,
  parameter int START_X     = 0,
  parameter int START_Y     = 0,
  parameter int INIT_STEP   = 1,
  parameter int MAX_STEP    = 8,
  parameter int RAMP_FRAMES = 120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              start,
  input  logic              pause,
  input  logic [X_W-1:0]    player_x,
  input  logic [Y_W-1:0]    player_y,
  output logic [X_W-1:0]    deadline_x,
  output logic [Y_W-1:0]    deadline_y,
  output logic              caught,
  output logic              running,
  output logic [STEP_W-1:0] step
);

  localparam int CNT_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  localparam int OFS   = PLAYER_SIZE/2 - SPRITE_SIZE/2;
  localparam logic [X_W-1:0] MAX_X = X_W'(SCREEN_W - SPRITE_SIZE);
  localparam logic [Y_W-1:0] MAX_Y = Y_W'(SCREEN_H - SPRITE_SIZE);

  logic [1:0]         state, state_nxt;
  logic [CNT_W-1:0]   frame_cnt;
  logic signed [X_W:0] tx;
  logic signed [Y_W:0] ty;
  pos_t               nxt;
  logic               hit, move, reload;

  // Centre the deadline on the player; may be negative near the top-left.
  assign tx = $signed({1'b0, player_x}) + $signed((X_W+1)'(OFS));
  assign ty = $signed({1'b0, player_y}) + $signed((Y_W+1)'(OFS));

  axis_stepper #(.W(X_W)) u_step_x (
    .pos(deadline_x), .target(tx), .step(step), .max_pos(MAX_X), .next_pos(nxt.x)
  );
  axis_stepper #(.W(Y_W)) u_step_y (
    .pos(deadline_y), .target(ty), .step(step), .max_pos(MAX_Y), .next_pos(nxt.y)
  );

  // Catch is judged on where the deadline lands this frame.
  assign hit = span_overlap(CMP_W'(player_x), CMP_W'(PLAYER_SIZE),
                            CMP_W'(nxt.x), CMP_W'(SPRITE_SIZE)) &&
               span_overlap(CMP_W'(player_y), CMP_W'(PLAYER_SIZE),
                            CMP_W'(nxt.y), CMP_W'(SPRITE_SIZE));

  assign move   = (state == ST_RUN) && frame_tick && !pause;
  assign reload = start && ((state == ST_IDLE) || (state == ST_CAUGHT));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_RUN;
      ST_RUN:    if (pause) state_nxt = ST_PAUSED;
                 else if (frame_tick && hit) state_nxt = ST_CAUGHT;
      ST_PAUSED: if (!pause) state_nxt = ST_RUN;
      ST_CAUGHT: if (start) state_nxt = ST_RUN;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      caught     <= 1'b0;
      running    <= 1'b0;
      deadline_x <= X_W'(START_X);
      deadline_y <= Y_W'(START_Y);
      step       <= STEP_W'(INIT_STEP);
      frame_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      caught  <= (state_nxt == ST_CAUGHT);
      running <= (state_nxt == ST_RUN);
      if (reload) begin
        deadline_x <= X_W'(START_X);
        deadline_y <= Y_W'(START_Y);
        step       <= STEP_W'(INIT_STEP);
        frame_cnt  <= '0;
      end else if (move) begin
        deadline_x <= nxt.x;
        deadline_y <= nxt.y;
        if (frame_cnt == CNT_W'(RAMP_FRAMES - 1)) begin
          frame_cnt <= '0;
          if (step < STEP_W'(MAX_STEP)) step <= step + STEP_W'(1);
        end else begin
          frame_cnt <= frame_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_deadline_tracker.sv
// Directed bench for deadline_tracker with a short speed ramp
// (RAMP_FRAMES=4, MAX_STEP=2); expected values are hand-derived.
module tb_deadline_tracker;

  logic        clk = 1'b0;
  logic        reset, frame_tick, start, pause;
  logic [10:0] player_x;
  logic [9:0]  player_y;
  logic [10:0] deadline_x;
  logic [9:0]  deadline_y;
  logic        caught, running;
  logic [3:0]  step;

  int n_assert = 0;
  int n_fail   = 0;
  int ex;

  deadline_tracker #(.RAMP_FRAMES(4), .MAX_STEP(2)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .pause(pause), .player_x(player_x), .player_y(player_y),
    .deadline_x(deadline_x), .deadline_y(deadline_y),
    .caught(caught), .running(running), .step(step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input int x, input int y);
    chk({tag, "_x"}, 32'(deadline_x), 32'(x));
    chk({tag, "_y"}, 32'(deadline_y), 32'(y));
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; start = 1'b0; pause = 1'b0;
    player_x = '0; player_y = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_pos("reset_pos", 0, 0);
    chk("reset_step", 32'(step), 1);
    chk("reset_caught", 32'(caught), 0);
    chk("reset_running", 32'(running), 0);

    tick();
    chk_pos("idle_hold", 0, 0);
    chk("idle_running", 32'(running), 0);

    // First chase frame: target (888,588) far away, move by 1
    player_x = 11'd1000; player_y = 10'd700;
    pulse_start();
    chk("start_running", 32'(running), 1);
    tick();
    chk_pos("first_tick", 1, 1);
    chk("first_step", 32'(step), 1);

    // pause coincident with frame_tick: pause wins
    @(negedge clk) begin pause = 1'b1; frame_tick = 1'b1; end
    @(negedge clk) frame_tick = 1'b0;
    chk("pause_running", 32'(running), 0);
    tick();
    tick();
    pulse_start();
    chk_pos("pause_hold", 1, 1);
    chk("pause_step", 32'(step), 1);
    chk("pause_caught", 32'(caught), 0);
    pause = 1'b0;
    @(negedge clk);
    chk("resume_running", 32'(running), 1);
    tick();
    chk_pos("resume_tick", 2, 2);
    tick();
    chk("step_before_ramp", 32'(step), 1);
    tick();
    chk_pos("ramp_edge", 4, 4);
    chk("step_after_ramp", 32'(step), 2);

    // Player at origin: negative target, step 2 toward it, overlap -> caught
    player_x = '0; player_y = '0;
    tick();
    chk_pos("neg_target", 2, 2);
    chk("catch_caught", 32'(caught), 1);
    chk("catch_running", 32'(running), 0);
    tick();
    chk_pos("caught_hold", 2, 2);

    pulse_start();
    chk_pos("restart_pos", 0, 0);
    chk("restart_step", 32'(step), 1);
    chk("restart_caught", 32'(caught), 0);
    tick();
    chk_pos("origin_clamp", 0, 0);
    chk("origin_caught", 32'(caught), 1);

    // Speed ramp with player far away: advance 1,1,1,1,2,2,...
    player_x = 11'd1280; player_y = 10'd1000;
    pulse_start();
    ex = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      ex += (k <= 4) ? 1 : 2;
      chk_pos($sformatf("ramp_k%0d", k), ex, ex);
      if (k == 4 || k == 12) chk($sformatf("ramp_step_k%0d", k), 32'(step), 2);
    end

    // Long run into the bottom-right clamp; player_x = dx+256 never overlaps
    repeat (520) tick();
    chk_pos("sat", 1024, 768);
    chk("sat_caught", 32'(caught), 0);
    chk("sat_running", 32'(running), 1);
    player_x = 11'd2047;
    tick();
    chk_pos("sat_no_wrap", 1024, 768);
    player_x = 11'd1270;
    tick();
    chk_pos("edge_catch_pos", 1024, 768);
    chk("edge_catch", 32'(caught), 1);

    // Reset wins over coincident frame_tick and start
    pulse_start();
    chk_pos("restart2_pos", 0, 0);
    tick();
    chk_pos("restart2_tick", 1, 1);
    @(negedge clk) begin reset = 1'b1; frame_tick = 1'b1; start = 1'b1; end
    @(negedge clk) begin reset = 1'b0; frame_tick = 1'b0; start = 1'b0; end
    chk_pos("midreset_pos", 0, 0);
    chk("midreset_running", 32'(running), 0);
    chk("midreset_caught", 32'(caught), 0);
    chk("midreset_step", 32'(step), 1);
    tick();
    chk_pos("post_reset_idle", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/deadline_tracker.md
Name: deadline_tracker

Overview:
- Produces the on-screen position of the deadline sprite.
- Drives the deadline_x/deadline_y inputs of the sprite display block, which only reads a position and renders a 256x256 ROM image there.
- Runs a small game state machine. The deadline moves toward the player once per frame, speeds up over time and flags a catch on overlap.
- Position changes only on frame_tick, so the display never tears mid-frame.

Parameters:
- SCREEN_W, 1280, visible width in pixels.
- SCREEN_H, 1024, visible height in pixels.
- SPRITE_SIZE, 256, deadline sprite edge length; must match the display block.
- PLAYER_SIZE, 32, player sprite edge length used for overlap.
- START_X, 0, deadline x loaded on reset/start.
- START_Y, 0, deadline y loaded on reset/start.
- INIT_STEP, 1, pixels moved per frame per axis at start.
- MAX_STEP, 8, step saturation value.
- RAMP_FRAMES, 120, RUN frames between step increments.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame, issued at start of vertical blank
- start  in  1  level/pulse; begins or restarts a chase
- pause  in  1  level; freezes movement while high
- player_x  in  11  player sprite top-left x
- player_y  in  10  player sprite top-left y
- deadline_x  out  11  deadline sprite top-left x
- deadline_y  out  10  deadline sprite top-left y
- caught  out  1  high while in CAUGHT state
- running  out  1  high while in RUN state
- step  out  4  current per-axis step, for HUD/debug

Behaviour:
Reset and clocking:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset. All outputs are registered.
- Reset values: state=IDLE, deadline_x=START_X, deadline_y=START_Y, step=INIT_STEP, frame counter=0, caught=0, running=0.
- Reset mid-operation overrides everything in that cycle, including a coincident frame_tick or start.

States:
- IDLE -> RUN when start=1. Reloads START_X/START_Y, step=INIT_STEP and counter=0 on the same edge.
- RUN -> PAUSED when pause=1; PAUSED -> RUN when pause=0. No movement and no counter advance while PAUSED.
- RUN -> CAUGHT on the frame_tick edge where the overlap test (computed on the post-move position) is true.
- CAUGHT -> RUN on start (reload as from IDLE). start is ignored in RUN and PAUSED.
- pause and frame_tick in the same RUN cycle: pause wins, no move.

Movement (on frame_tick in RUN only):
- Target: tx = player_x + PLAYER_SIZE/2 - SPRITE_SIZE/2, computed in 12-bit signed. Likewise ty (11-bit signed).
- Per axis: if |target - pos| <= step, pos = target; else pos moves by step toward target.
- Result is clamped to [0, SCREEN_W-SPRITE_SIZE] for x and [0, SCREEN_H-SPRITE_SIZE] for y. Negative targets clamp to 0; no unsigned wrap is permitted.
- New position is visible on outputs one cycle after the frame_tick cycle.

Speed ramp:
- Frame counter increments on each RUN frame_tick.
- When it reaches RAMP_FRAMES-1 it returns to 0, and step increments, saturating at MAX_STEP.

Overlap test:
- Axis-aligned boxes; touching edges do not count.
- Overlap iff player_x < dx+SPRITE_SIZE && player_x+PLAYER_SIZE > dx, and likewise for y. Evaluated at 12-bit width to avoid overflow.

Outputs:
- caught = (state==CAUGHT); running = (state==RUN).
- Position holds constant in IDLE, PAUSED and CAUGHT.

Decomposition:
- Shared game package: state encoding (IDLE=0, RUN=1, PAUSED=2, CAUGHT=3), SCREEN_W/SCREEN_H, SPRITE_SIZE, coordinate widths (X_W=11, Y_W=10).
- One natural sub-module: axis_stepper, instantiated twice. It takes pos, target, step, max_pos and returns the clamped next pos, combinationally.

Test Plan:
- Reset, then start, player at (1000,700), 1 frame_tick -> deadline=(1,1), running=1, step=1.
- From (0,0) with player at (0,0): targets clamp to 0 -> position stays (0,0); caught=1 after that tick (overlap).
- RAMP_FRAMES=4, MAX_STEP=2, player far: 4 ticks -> step=2; 8 more ticks -> step stays 2; x advance per tick 1,1,1,1,2,2,...
- pause held high across 3 frame_ticks -> deadline_x/deadline_y and step unchanged; release, then 1 tick -> moves by step.
- Player at (1270,1000): x saturates at 1024, y at 768, no wrap; player exactly at dx+256 -> caught=0.
- CAUGHT then start -> position=(START_X,START_Y), step=INIT_STEP. reset asserted together with frame_tick in RUN -> IDLE, START position, caught=0.
